// File: rtl/sim_ram_arb.sv
// Round-robin bridge from NCH core request channels to one 64-bit RAMHelper-style port.
// Define SIM_RAM_ARB_ERR_EN to flag out-of-range or misaligned addresses instead of wrapping.
module sim_ram_arb #(
    parameter int          NCH  = 2,
    parameter int          AW   = 16,
    parameter logic [63:0] BASE = 64'h8000_0000,
    parameter int          LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    ch_cen_i,
    input  logic [NCH-1:0]    ch_wen_i,
    input  logic [NCH*64-1:0] ch_addr_i,
    input  logic [NCH*64-1:0] ch_wdata_i,
    input  logic [NCH*8-1:0]  ch_wmask_i,
    output logic [NCH-1:0]    ch_ready_o,
    output logic [63:0]       ch_rdata_o,
    output logic              ch_err_o,
    output logic              busy_o,
    output logic              mem_en_o,
    output logic              mem_wen_o,
    output logic [AW-1:0]     mem_idx_o,
    output logic [63:0]       mem_wdata_o,
    output logic [63:0]       mem_wmask_o,
    input  logic [63:0]       mem_rdata_i
);
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    function automatic logic [63:0] expand_mask(input logic [7:0] m);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[8*b +: 8] = {8{m[b]}};
        return r;
    endfunction

    state_t         state_q;
    logic [GW-1:0]  rr_q, gnt_q, gnt_d, rr_d;
    logic [2:0]     cnt_q;
    logic [63:0]    rdata_q;
    logic           err_q, ch_err_q, busy_q;
    logic [NCH-1:0] ready_q;
    logic           mem_en_q, mem_wen_q;
    logic [AW-1:0]  mem_idx_q;
    logic [63:0]    mem_wdata_q, mem_wmask_q;

    logic           any_d, sel_wen, sel_err;
    logic [63:0]    sel_addr, sel_wdata;
    logic [7:0]     sel_wmask;
    logic [AW-1:0]  sel_idx;

    // First requester at or after the round-robin pointer, wrapping modulo NCH.
    always_comb begin
        int j;
        j     = 0;
        any_d = 1'b0;
        gnt_d = '0;
        for (int i = 0; i < NCH; i++) begin
            j = int'(rr_q) + i;
            if (j >= NCH) j = j - NCH;
            if (!any_d && ch_cen_i[j]) begin
                any_d = 1'b1;
                gnt_d = GW'(j);
            end
        end
    end

    always_comb begin
        sel_wen   = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wmask = '0;
        for (int k = 0; k < NCH; k++) begin
            if (gnt_d == GW'(k)) begin
                sel_wen   = ch_wen_i[k];
                sel_addr  = ch_addr_i[64*k +: 64];
                sel_wdata = ch_wdata_i[64*k +: 64];
                sel_wmask = ch_wmask_i[8*k +: 8];
            end
        end
    end

    assign sel_idx = AW'((sel_addr - BASE) >> 3);
    assign rr_d    = (gnt_q == GW'(NCH - 1)) ? '0 : gnt_q + 1'b1;

`ifdef SIM_RAM_ARB_ERR_EN
    localparam logic [63:0] TOP = BASE + (64'd8 << AW);
    assign sel_err = (sel_addr < BASE) || (sel_addr >= TOP) || (sel_addr[2:0] != 3'b000);
`else
    assign sel_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            gnt_q       <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            ch_err_q    <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_idx_q   <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_d) begin
                        gnt_q       <= gnt_d;
                        err_q       <= sel_err;
                        mem_en_q    <= ~sel_err;
                        mem_wen_q   <= sel_wen;
                        mem_idx_q   <= sel_idx;
                        mem_wdata_q <= sel_wdata;
                        mem_wmask_q <= sel_wen ? expand_mask(sel_wmask) : '0;
                        busy_q      <= 1'b1;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (err_q)
                        rdata_q <= '0;
                    else if (!mem_wen_q)
                        rdata_q <= mem_rdata_i;
                    mem_en_q    <= 1'b0;
                    mem_wen_q   <= 1'b0;
                    mem_idx_q   <= '0;
                    mem_wdata_q <= '0;
                    mem_wmask_q <= '0;
                    cnt_q       <= 3'(LAT - 1);
                    if (LAT == 1) begin
                        ready_q  <= NCH'(1) << gnt_q;
                        ch_err_q <= err_q;
                        state_q  <= RESP;
                    end else begin
                        state_q  <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        ready_q  <= NCH'(1) << gnt_q;
                        ch_err_q <= err_q;
                        state_q  <= RESP;
                    end
                end
                RESP: begin
                    ready_q  <= '0;
                    ch_err_q <= 1'b0;
                    busy_q   <= 1'b0;
                    rr_q     <= rr_d;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ch_ready_o  = ready_q;
    assign ch_rdata_o  = rdata_q;
    assign ch_err_o    = ch_err_q;
    assign busy_o      = busy_q;
    assign mem_en_o    = mem_en_q;
    assign mem_wen_o   = mem_wen_q;
    assign mem_idx_o   = mem_idx_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wmask_o = mem_wmask_q;
endmodule

// File: doc/sim_ram_arb.md
# sim_ram_arb

- Parametrised simulation-memory bridge between `NCH` core request channels and one 64-bit RAMHelper-style memory port.
- Replaces the single-channel cen/ready glue in the simulation top, which supported one requester, fixed latency and no address checking.
- Adds:
  - round-robin arbitration;
  - programmable response latency;
  - byte-mask expansion;
  - optional out-of-range address detection.
- Sits in the simulation top between the `rvcpu` memory ports (instruction fetch, load/store) and the RAMHelper instance.

## Interface

Parameters:

- `NCH`, 2 — number of request channels (1..8).
- `AW`, 16 — memory index width; memory holds 2^AW 64-bit words.
- `BASE`, 64'h8000_0000 — byte address of memory word 0.
- `LAT`, 1 — memory-to-response latency in cycles (1..8).

Ports:

- `clk`  in  1  — clock.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `ch_cen_i`  in  NCH  — per-channel request valid.
- `ch_wen_i`  in  NCH  — per-channel write (1) / read (0).
- `ch_addr_i`  in  NCH*64  — byte addresses, channel k at [64k+63:64k].
- `ch_wdata_i`  in  NCH*64  — write data.
- `ch_wmask_i`  in  NCH*8  — byte write enables.
- `ch_ready_o`  out  NCH  — one-cycle completion pulse, one-hot or zero.
- `ch_rdata_o`  out  64  — read data, valid while any `ch_ready_o` bit is 1.
- `ch_err_o`  out  1  — out-of-range flag, valid with `ch_ready_o`.
- `busy_o`  out  1  — transaction in flight.
- `mem_en_o`  out  1  — memory enable.
- `mem_wen_o`  out  1  — memory write enable.
- `mem_idx_o`  out  AW  — memory word index.
- `mem_wdata_o`  out  64  — memory write data.
- `mem_wmask_o`  out  64  — bit mask, each byte enable replicated 8×.
- `mem_rdata_i`  in  64  — memory read data, valid in the same cycle as `mem_en_o`.

## Operation

- Requester protocol:
  - The requester raises `ch_cen_i[k]` and holds cen, wen, addr, wdata and wmask stable until it sees `ch_ready_o[k]`.
  - Once granted, a transaction always completes, even if cen drops early.
- One transaction in flight; no pipelining. FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - If any cen is set, grant the first requester at or after round-robin pointer `rr` (wrapping modulo NCH).
  - Latch the grant index and the channel's fields into registers; go to ACCESS.
- ACCESS (one cycle):
  - `mem_en_o`=1.
  - `mem_idx_o` = ((addr − BASE) >> 3)[AW-1:0].
  - `mem_wen_o` = latched wen.
  - `mem_wdata_o` = latched wdata.
  - `mem_wmask_o` = expanded wmask when writing, 0 when reading.
  - Capture `mem_rdata_i` into the rdata register on a read; leave it unchanged on a write.
  - Load latency counter with LAT−1; go to RESP if LAT==1, else WAIT.
- WAIT: decrement counter; go to RESP when the counter reaches 0.
- RESP:
  - `ch_ready_o[grant]`=1; `ch_rdata_o` = rdata register.
  - `rr` ← grant+1 (wrap to 0 at NCH); go to IDLE.
- `busy_o`=1 in ACCESS, WAIT and RESP.
- All memory-side outputs are 0 outside ACCESS.
- `ch_rdata_o` holds its last value outside RESP; consumers qualify it with `ch_ready_o`.
- Reset values: state IDLE, `rr`=0, counter 0, rdata register 0, every output 0.
- Reset asserted mid-transaction aborts it; no ready pulse is issued afterwards.

## Timing

- A request sampled in IDLE at cycle t gives ACCESS at t+1 and `ch_ready_o` at t+1+LAT.
- Back-to-back: after RESP at cycle r, IDLE at r+1 samples the next request.
  - Single-requester throughput: one transaction per LAT+2 cycles.
- Simultaneous requests: the lowest index at or after `rr` wins; the others wait.
  - A continuously requesting channel waits at most NCH−1 transactions.
- NCH=1: `rr` is constant 0.

## Configuration

- `SIM_RAM_ARB_ERR_EN` defined:
  - At grant, flag the address out-of-range if addr < BASE, or addr ≥ BASE + 8·2^AW, or addr[2:0] ≠ 0.
  - A flagged transaction follows the same FSM and timing but keeps `mem_en_o`=0 in ACCESS and returns rdata 0.
  - `ch_err_o`=1 during its RESP.
- `SIM_RAM_ARB_ERR_EN` undefined:
  - No checking; the index is truncated to AW bits, so accesses wrap modulo memory size.
  - `ch_err_o` is tied 0.

## Test plan

- Single read, LAT=1: ch0 reads 0x8000_0010, memory word 2 = 0x1122334455667788 → `mem_idx_o`=2 at t+1; `ch_ready_o`=01 at t+2; `ch_rdata_o`=0x1122334455667788.
- Masked write: ch1 writes 0x8000_0008 with wdata 0xFFFF_FFFF_FFFF_FFFF and wmask 8'h0F → `mem_wmask_o`=64'h0000_0000_FFFF_FFFF, `mem_wen_o`=1, `mem_idx_o`=1; a readback of the word shows only the low 4 bytes changed.
- Contention, NCH=2: both channels hold cen from reset → grants alternate ch0, ch1, ch0; ready pulses every LAT+2 cycles, never two bits set.
- Latency sweep LAT=4: read request at t → `mem_en_o` at t+1 only; ready at t+5; `busy_o` high t+1..t+5.
- Reset mid-transaction: `rst_n` low during WAIT → all outputs 0 immediately; no ready pulse; after release, a new ch1 request completes normally with `rr`=0.
- With `SIM_RAM_ARB_ERR_EN`: read of 0x7FFF_FFF8 → `mem_en_o` stays 0; ready with rdata 0 and `ch_err_o`=1.
- Without `SIM_RAM_ARB_ERR_EN`: read of BASE+8·2^AW hits index 0 with `ch_err_o`=0.
